imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/imem_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared loader / instruction-memory definitions: memory size, length width, state encoding.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state used for the trailing XOR byte.
package mips_pkg;

    localparam int unsigned IMEM_BYTES = 512;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned ADDR_W     = 9;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_LOAD, ST_CHK, ST_FIN, ST_ERR
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_LOAD, ST_FIN, ST_ERR
    } loader_state_t;
`endif

    typedef struct packed {
        logic byte_ready;
        logic cpu_hold;
        logic done;
        logic error;
    } loader_ctrl_t;

    // Output levels for a state; the FSM registers these together with the state.
    function automatic loader_ctrl_t ctrl_of(input loader_state_t s);
        loader_ctrl_t c;
        c.byte_ready = !((s == ST_IDLE) || (s == ST_FIN) || (s == ST_ERR));
        c.cpu_hold   = !((s == ST_IDLE) || (s == ST_FIN));
        c.done       = (s == ST_FIN);
        c.error      = (s == ST_ERR);
        return c;
    endfunction

    // A payload length must be non-zero, fit the memory and be whole 32-bit words.
    function automatic logic len_invalid(input logic [LEN_W-1:0] len,
                                         input int unsigned      max_bytes);
        return (len == '0) || (32'(len) > max_bytes) || (len[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into external instruction memory while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int unsigned IMEM_BYTES = mips_pkg::IMEM_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       mem_we,
    output logic [8:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       error
);
    import mips_pkg::*;

    loader_state_t     state_reg;
    loader_ctrl_t      ctrl_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic             xfer;
    logic [LEN_W-1:0] len_cand;
    logic             last_byte;

    assign xfer      = byte_valid && ctrl_reg.byte_ready;
    assign len_cand  = {len_reg[15:8], byte_data};
    assign last_byte = (LEN_W'(cnt_reg) == (len_reg - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            ctrl_reg      <= ctrl_of(ST_IDLE);
            len_reg       <= '0;
            cnt_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            mem_we_reg <= 1'b0;
            unique case (state_reg)
                // FIN and ERR accept start as a restart; IDLE accepts it as the first load.
                ST_IDLE, ST_FIN, ST_ERR: begin
                    if (start) begin
                        state_reg <= ST_LEN_HI;
                        ctrl_reg  <= ctrl_of(ST_LEN_HI);
                        len_reg   <= '0;
                        cnt_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg  <= '0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_reg[15:8] <= byte_data;
                        state_reg     <= ST_LEN_LO;
                        ctrl_reg      <= ctrl_of(ST_LEN_LO);
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_reg[7:0] <= byte_data;
                        if (len_invalid(len_cand, IMEM_BYTES)) begin
                            state_reg <= ST_ERR;
                            ctrl_reg  <= ctrl_of(ST_ERR);
                        end else begin
                            state_reg <= ST_LOAD;
                            ctrl_reg  <= ctrl_of(ST_LOAD);
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= cnt_reg[ADDR_W-1:0];
                        mem_wdata_reg <= byte_data;
                        cnt_reg       <= cnt_reg + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg      <= csum_reg ^ byte_data;
                        if (last_byte) begin
                            state_reg <= ST_CHK;
                            ctrl_reg  <= ctrl_of(ST_CHK);
                        end
`else
                        if (last_byte) begin
                            state_reg <= ST_FIN;
                            ctrl_reg  <= ctrl_of(ST_FIN);
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) begin
                        if (byte_data == csum_reg) begin
                            state_reg <= ST_FIN;
                            ctrl_reg  <= ctrl_of(ST_FIN);
                        end else begin
                            state_reg <= ST_ERR;
                            ctrl_reg  <= ctrl_of(ST_ERR);
                        end
                    end
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                    ctrl_reg  <= ctrl_of(ST_IDLE);
                end
            endcase
        end
    end

    assign byte_ready = ctrl_reg.byte_ready;
    assign cpu_hold   = ctrl_reg.cpu_hold;
    assign done       = ctrl_reg.done;
    assign error      = ctrl_reg.error;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule
